vector_add_sched: RTL
=====================

Name: vector_add_sched

Overview:
- Sequencing controller for the per-lane floating-point vector adder used for bias addition after the matrix unit.
- Accepts a job command carrying a row count and a bias vector, then streams input rows into the adder with valid/ready handshaking.
- Tracks rows in flight through the adder's fixed-latency pipeline and buffers results in a credit-protected output FIFO, so downstream backpressure never drops a result.

Parameters:
- DATA_WIDTH, 16, width of one lane element.
- LENGTH, 4, lanes per vector.
- ADD_LAT, 3, adder latency in cycles from issue to result, with adder_en held high.
- OUT_DEPTH, 4, output FIFO entries; must be >= 2.
- CNT_W, 16, width of the row counters and of cmd_rows.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset; 0 = reset.
- cmd_valid  in  1  job command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_rows  in  CNT_W  rows in job.
- cmd_bias  in  LENGTH*DATA_WIDTH  bias vector; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  in  1  input row valid.
- in_ready  out  1  row accepted when in_valid&&in_ready.
- in_x  in  LENGTH*DATA_WIDTH  input row.
- adder_en  out  1  adder pipeline advance.
- adder_x  out  LENGTH*DATA_WIDTH  operand A to adder.
- adder_bias  out  LENGTH*DATA_WIDTH  operand B, the latched bias.
- adder_result  in  LENGTH*DATA_WIDTH  adder output.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accept.
- out_data  out  LENGTH*DATA_WIDTH  FIFO head.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset, asynchronous on reset=0: FSM=IDLE; counters, in-flight shift register and FIFO pointers/count cleared; bias register 0; adder_x registered 0; out_valid=0, busy=0, done=0, in_ready=0, adder_en=0, cmd_ready=1 after reset release.
- Reset mid-job: all in-flight and buffered rows are discarded; no done pulse.
- FSM IDLE -> RUN on cmd_valid&&cmd_ready:
  - Latch cmd_bias and cmd_rows.
  - Clear issued_cnt and retired_cnt.
  - If cmd_rows==0, go to DONE instead of RUN.
- RUN:
  - adder_en=1.
  - in_ready = (issued_cnt < rows) && (inflight + fifo_count < OUT_DEPTH).
  - On a handshake, adder_x is registered from in_x and inflight_sr[0] is set; issued_cnt increments.
  - When the last row issues, go to DRAIN.
- DRAIN: adder_en=1; in_ready=0. When retired_cnt==rows, in-flight is 0, and the FIFO is empty, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. Only 1-cycle DONE; no stall in DONE.
- adder_en is 0 in IDLE and DONE.
- In-flight tracking:
  - ADD_LAT-bit shift register advancing every cycle while adder_en=1.
  - When the bit exits, adder_result is written to the FIFO in that same cycle and retired_cnt increments.
  - inflight is the popcount of the register, kept as an up/down counter.
- Total issue-to-out_valid latency is ADD_LAT+2 cycles: 1 cycle for the operand register, ADD_LAT for the adder, 1 cycle for the FIFO write.
- Credit rule: inflight + fifo_count never exceeds OUT_DEPTH, so the FIFO cannot overflow; a write into a full FIFO is an assertion failure.
- FIFO:
  - Simultaneous write and read with count in 1..OUT_DEPTH-1 keeps count unchanged.
  - A write into an empty FIFO becomes visible on out_valid the next cycle; there is no fall-through.
  - Pointers wrap modulo OUT_DEPTH.
- out_data holds stable while out_valid && !out_ready.
- in_valid low during RUN: no issue, and no bubble penalty beyond the lost cycle.
- cmd_valid outside IDLE is ignored.
- Lane values pass through bit-exact; the controller does no arithmetic on data.

Optional Feature:
- Macro VADD_SCHED_PERF_EN.
- When defined:
  - Adds outputs perf_stall_cnt [31:0], counting RUN cycles with in_valid=1 && in_ready=0 (credit stalls).
  - Adds perf_busy_cnt [31:0], counting cycles with busy=1.
  - Both counters clear on reset and on job accept, and saturate at all-ones.
- When undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Reset then cmd_rows=4, bias lanes 0x3C00 (1.0), in_valid held high, out_ready=1 -> 4 rows issued on consecutive cycles; first out_valid 5 cycles after first issue (ADD_LAT=3); done pulses once after the 4th row retires; busy falls the same cycle done rises.
- cmd_rows=0 -> DONE the cycle after accept; done pulse; no in_ready, no adder_en.
- cmd_rows=10, out_ready=0 -> exactly OUT_DEPTH=4 rows issued, then in_ready stays 0; FIFO holds 4 entries with out_data stable. Releasing out_ready -> remaining 6 drain in order and done pulses once.
- Toggle out_ready 1/0 each cycle with cmd_rows=8 -> all 8 results delivered in issue order with no loss or duplication; FIFO count never exceeds 4.
- Assert reset=0 during DRAIN with 2 rows in flight -> outputs return to reset values asynchronously; after release cmd_ready=1, out_valid=0, and no done pulse.
- With VADD_SCHED_PERF_EN defined, run the third scenario -> perf_stall_cnt equals the cycles in_valid was blocked; perf_busy_cnt equals the busy-high cycles.

Source files
------------

// File: rtl/vector_add_sched_if.sv
// Command, input-row, adder and output-stream signals of vector_add_sched.
// Perf counter wires exist only when VADD_SCHED_PERF_EN is defined.
interface vector_add_sched_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LENGTH     = 4,
    parameter int CNT_W      = 16
);
    localparam int VW = LENGTH * DATA_WIDTH;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_rows;
    logic [VW-1:0]    cmd_bias;
    logic             in_valid;
    logic             in_ready;
    logic [VW-1:0]    in_x;
    logic             adder_en;
    logic [VW-1:0]    adder_x;
    logic [VW-1:0]    adder_bias;
    logic [VW-1:0]    adder_result;
    logic             out_valid;
    logic             out_ready;
    logic [VW-1:0]    out_data;
    logic             busy;
    logic             done;
`ifdef VADD_SCHED_PERF_EN
    logic [31:0]      perf_stall_cnt;
    logic [31:0]      perf_busy_cnt;
`endif

    modport master (
        output cmd_valid, cmd_rows, cmd_bias, in_valid, in_x, adder_result, out_ready,
        input  cmd_ready, in_ready, adder_en, adder_x, adder_bias, out_valid, out_data, busy, done
`ifdef VADD_SCHED_PERF_EN
        , input perf_stall_cnt, perf_busy_cnt
`endif
    );

    modport slave (
        input  cmd_valid, cmd_rows, cmd_bias, in_valid, in_x, adder_result, out_ready,
        output cmd_ready, in_ready, adder_en, adder_x, adder_bias, out_valid, out_data, busy, done
`ifdef VADD_SCHED_PERF_EN
        , output perf_stall_cnt, perf_busy_cnt
`endif
    );
endinterface

// File: rtl/vector_add_sched.sv
// Bias-add sequencer: streams rows into a fixed-latency vector adder, credit-protects the output FIFO.
// Optional perf counters under macro VADD_SCHED_PERF_EN.
module vector_add_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int LENGTH     = 4,
    parameter int ADD_LAT    = 3,
    parameter int OUT_DEPTH  = 4,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic reset,
    vector_add_sched_if.slave bus
);
    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = $clog2(OUT_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                              state, state_nxt;
    logic [CNT_W-1:0]                    rows, issued_cnt, retired_cnt;
    logic [LENGTH-1:0][DATA_WIDTH-1:0]   bias_q, x_q;
    // bit 0 marks the operand register, bits 1..ADD_LAT the adder stages
    logic [ADD_LAT:0]                    vld_pipe;
    logic [CW-1:0]                       inflight, fifo_count;
    logic [OUT_DEPTH-1:0][LENGTH-1:0][DATA_WIDTH-1:0] mem;
    logic [PW-1:0]                       wr_ptr, rd_ptr;
    logic                                adv, accept, in_rdy, issue, retire, pop, credit_ok;

    assign adv       = (state == RUN) || (state == DRAIN);
    assign accept    = (state == IDLE) && bus.cmd_valid;
    assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < (CW+1)'(OUT_DEPTH);
    assign in_rdy    = (state == RUN) && (issued_cnt < rows) && credit_ok;
    assign issue     = in_rdy && bus.in_valid;
    assign retire    = adv && vld_pipe[ADD_LAT];
    assign pop       = bus.out_valid && bus.out_ready;

    assign bus.cmd_ready  = (state == IDLE);
    assign bus.in_ready   = in_rdy;
    assign bus.adder_en   = adv;
    assign bus.adder_x    = x_q;
    assign bus.adder_bias = bias_q;
    assign bus.out_valid  = (fifo_count != '0);
    assign bus.out_data   = mem[rd_ptr];
    assign bus.busy       = adv;
    assign bus.done       = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = (bus.cmd_rows == '0) ? DONE : RUN;
            RUN:   if (issue && (issued_cnt + CNT_W'(1)) == rows) state_nxt = DRAIN;
            DRAIN: if (retired_cnt == rows && inflight == '0 && fifo_count == '0) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rows        <= '0;
            issued_cnt  <= '0;
            retired_cnt <= '0;
            bias_q      <= '0;
            x_q         <= '0;
            vld_pipe    <= '0;
            inflight    <= '0;
        end else begin
            if (accept) begin
                rows        <= bus.cmd_rows;
                bias_q      <= bus.cmd_bias;
                issued_cnt  <= '0;
                retired_cnt <= '0;
            end else begin
                if (issue)  issued_cnt  <= issued_cnt + CNT_W'(1);
                if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
            end
            if (issue) x_q      <= bus.in_x;
            if (adv)   vld_pipe <= {vld_pipe[ADD_LAT-1:0], issue};
            inflight <= inflight + CW'(issue) - CW'(retire);
        end
    end

    // Output FIFO: written by the retiring pipeline slot, registered head (no fall-through)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (retire) wr_ptr <= (wr_ptr == PW'(OUT_DEPTH-1)) ? '0 : wr_ptr + PW'(1);
            if (pop)    rd_ptr <= (rd_ptr == PW'(OUT_DEPTH-1)) ? '0 : rd_ptr + PW'(1);
            fifo_count <= fifo_count + CW'(retire) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (retire) mem[wr_ptr] <= bus.adder_result;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(retire && fifo_count == CW'(OUT_DEPTH)));

`ifdef VADD_SCHED_PERF_EN
    logic [31:0] stall_q, busyc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            busyc_q <= '0;
        end else if (accept) begin
            stall_q <= '0;
            busyc_q <= '0;
        end else begin
            if (state == RUN && bus.in_valid && !in_rdy && stall_q != '1) stall_q <= stall_q + 32'd1;
            if (adv && busyc_q != '1) busyc_q <= busyc_q + 32'd1;
        end
    end

    assign bus.perf_stall_cnt = stall_q;
    assign bus.perf_busy_cnt  = busyc_q;
`endif
endmodule
